// File: rtl/key_filter_pkg.sv
// Shared types and elaboration-time helpers for the key filter.
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_fsm_e;

  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  // Minimum result of 1 so a counter width is never zero.
  function automatic int clog2_f(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >>> 1;
    end
    return (res < 1) ? 1 : res;
  endfunction

endpackage

// File: rtl/key_filter_ch.sv
// Single-key conditioner: synchroniser, debounce FSM, long-press timer.
module key_filter_ch
  import key_filter_pkg::*;
#(
  parameter int DB_CYCLES   = 4,
  parameter int LONG_CYCLES = 20,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_pulse,
  output logic key_release,
  output logic key_long,
  output logic key_state
);

  localparam int DB_W   = clog2_f(DB_CYCLES + 1);
  localparam int HOLD_W = clog2_f(LONG_CYCLES + 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic              IDLE_LEVEL = ACTIVE_LOW;

  logic sync1;
  logic sync2;
  logic key_s;

  key_fsm_e          state, state_n;
  logic [DB_W-1:0]   db_cnt, db_cnt_n;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_n;
  logic              long_done, long_done_n;
  logic              pulse_n, release_n, long_n, level_n;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= IDLE_LEVEL;
      sync2 <= IDLE_LEVEL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_s = ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      db_cnt      <= '0;
      hold_cnt    <= '0;
      long_done   <= 1'b0;
      key_pulse   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      key_state   <= 1'b0;
    end else begin
      state       <= state_n;
      db_cnt      <= db_cnt_n;
      hold_cnt    <= hold_cnt_n;
      long_done   <= long_done_n;
      key_pulse   <= pulse_n;
      key_release <= release_n;
      key_long    <= long_n;
      key_state   <= level_n;
    end
  end

  always_comb begin
    state_n     = state;
    db_cnt_n    = db_cnt;
    hold_cnt_n  = hold_cnt;
    long_done_n = long_done;
    pulse_n     = 1'b0;
    release_n   = 1'b0;
    long_n      = 1'b0;
    level_n     = key_state;

    case (state)
      IDLE: begin
        if (key_s) begin
          state_n  = PRESS_WAIT;
          db_cnt_n = DB_W'(1);
        end else begin
          db_cnt_n = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_s) begin
          state_n  = IDLE;
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n     = PRESSED;
          db_cnt_n    = '0;
          hold_cnt_n  = '0;
          long_done_n = 1'b0;
          pulse_n     = 1'b1;
          level_n     = 1'b1;
        end else begin
          db_cnt_n = db_cnt + DB_W'(1);
        end
      end
      PRESSED: begin
        if (!key_s) begin
          state_n  = RELEASE_WAIT;
          db_cnt_n = DB_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (key_s) begin
          state_n  = PRESSED;
          db_cnt_n = '0;
        end else if (db_cnt == DB_LAST) begin
          state_n   = IDLE;
          db_cnt_n  = '0;
          release_n = 1'b1;
          level_n   = 1'b0;
        end else begin
          db_cnt_n = db_cnt + DB_W'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        db_cnt_n = '0;
      end
    endcase

    // Hold timer runs through release bounces and saturates after the long event.
    if ((state == PRESSED || state == RELEASE_WAIT) && !long_done) begin
      if (hold_cnt == HOLD_LAST) begin
        long_n      = 1'b1;
        long_done_n = 1'b1;
      end else begin
        hold_cnt_n = hold_cnt + HOLD_W'(1);
      end
    end
  end

endmodule

// File: rtl/key_filter.sv
// N independent key conditioners feeding the countdown/display control.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int N           = 1,
  parameter int CLK_HZ      = 12000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key_in,
  output logic [N-1:0] key_pulse,
  output logic [N-1:0] key_release,
  output logic [N-1:0] key_long,
  output logic [N-1:0] key_state
);

  localparam int DB_CYCLES   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYCLES = ms_to_cycles(CLK_HZ, LONG_MS);

  generate
    if (DB_CYCLES < 2) begin : g_bad_db
      $error("key_filter: debounce window shorter than 2 cycles");
    end
    if (LONG_CYCLES <= DB_CYCLES) begin : g_bad_long
      $error("key_filter: long-press time must exceed debounce time");
    end
  endgenerate

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_filter_ch #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_in     (key_in[i]),
      .key_pulse  (key_pulse[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i]),
      .key_state  (key_state[i])
    );
  end

endmodule

// File: tb/tb_key_filter.sv
// Directed bench for key_filter with two active-low keys, 4-cycle debounce, 20-cycle long press.
module tb_key_filter;

  logic       clk;
  logic       rst;
  logic [1:0] key_in;
  logic [1:0] key_pulse;
  logic [1:0] key_release;
  logic [1:0] key_long;
  logic [1:0] key_state;

  int assert_count;
  int fail_count;

  key_filter #(
    .N          (2),
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(4),
    .LONG_MS    (20),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_pulse  (key_pulse),
    .key_release(key_release),
    .key_long   (key_long),
    .key_state  (key_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the raw keys, let one rising edge pass, settle 1 time unit.
  task automatic applyStimulus(input logic [1:0] keys);
    key_in = keys;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %b expected %b (pulse,release,long,state x2)", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] key0(input logic p, input logic r, input logic l, input logic s);
    return {1'b0, p, 1'b0, r, 1'b0, l, 1'b0, s};
  endfunction

  function automatic logic [7:0] outs();
    return {key_pulse, key_release, key_long, key_state};
  endfunction

  initial begin
    logic bit0;
    assert_count = 0;
    fail_count   = 0;
    rst    = 1'b1;
    key_in = 2'b11;

    for (int i = 0; i < 3; i++) applyStimulus(2'b11);
    checkOutput("reset", outs(), 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(2'b11);
      checkOutput("post_reset_idle", outs(), 8'h00);
    end

    $display("[TB] clean press with long hold");
    for (int e = 0; e < 30; e++) begin
      applyStimulus(2'b10);
      checkOutput($sformatf("press_e%0d", e), outs(), key0(e == 5, 1'b0, e == 25, e >= 5));
    end

    $display("[TB] release with bounce");
    for (int e = 0; e < 13; e++) begin
      bit0 = (e == 2) ? 1'b0 : 1'b1;
      applyStimulus({1'b1, bit0});
      checkOutput($sformatf("release_e%0d", e), outs(), key0(1'b0, e == 8, 1'b0, e < 8));
    end

    $display("[TB] press bounce rejected");
    for (int e = 0; e < 12; e++) begin
      bit0 = (e == 0 || e == 1 || e == 3 || e == 4) ? 1'b0 : 1'b1;
      applyStimulus({1'b1, bit0});
      checkOutput($sformatf("bounce_e%0d", e), outs(), 8'h00);
    end

    $display("[TB] short press");
    for (int e = 0; e < 31; e++) begin
      bit0 = (e < 13) ? 1'b0 : 1'b1;
      applyStimulus({1'b1, bit0});
      checkOutput($sformatf("short_e%0d", e), outs(), key0(e == 5, e == 18, 1'b0, e >= 5 && e < 18));
    end

    $display("[TB] reset while held");
    for (int e = 0; e < 11; e++) begin
      applyStimulus(2'b10);
      checkOutput($sformatf("hold_e%0d", e), outs(), key0(e == 5, 1'b0, 1'b0, e >= 5));
    end
    rst = 1'b1;
    applyStimulus(2'b10);
    checkOutput("mid_reset", outs(), 8'h00);
    rst = 1'b0;
    for (int e = 0; e < 9; e++) begin
      applyStimulus(2'b10);
      checkOutput($sformatf("repress_e%0d", e), outs(), key0(e == 5, 1'b0, 1'b0, e >= 5));
    end
    for (int e = 0; e < 8; e++) begin
      applyStimulus(2'b11);
      checkOutput($sformatf("rerelease_e%0d", e), outs(), key0(1'b0, e == 5, 1'b0, e < 5));
    end
    for (int i = 0; i < 3; i++) applyStimulus(2'b11);

    $display("[TB] two keys together");
    for (int e = 0; e < 9; e++) begin
      applyStimulus(2'b00);
      checkOutput($sformatf("dual_e%0d", e), outs(),
                  {(e == 5) ? 2'b11 : 2'b00, 2'b00, 2'b00, (e >= 5) ? 2'b11 : 2'b00});
    end
    for (int e = 0; e < 8; e++) begin
      applyStimulus(2'b10);
      checkOutput($sformatf("key1_release_e%0d", e), outs(),
                  {2'b00, (e == 5) ? 2'b10 : 2'b00, 2'b00, (e >= 5) ? 2'b01 : 2'b11});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
